pad_uart_reporter: RTL and testbench

- Downstream consumer of the 12-bit gamepad button vector from the ESP32 SPI gamepad receiver.
- Sends an ASCII report frame over a UART TX line whenever the button state changes, or when a report is explicitly requested.
- Used for console-side debug of Bluetooth pad input through the FTDI UART, without needing the LEDs.

---
 rtl/pad_uart_reporter.sv | 192 +++++++++++++++++++
 tb/tb_pad_uart_reporter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pad_uart_reporter.sv
// pad_uart_reporter
// Sends an ASCII report "P<h2><h1><h0>\r\n" of the 12-bit gamepad button
// vector over an 8N1 UART line. A report is sent whenever the button vector
// differs from the last reported value, or when force_report asks for one.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       synchronous reset, active low
//   pad_btn[11:0] button vector, synchronous to clk
//   enable        gates the start of new frames (a running frame completes)
//   force_report  single-cycle request for one frame
//   uart_tx       serial output, idle high (registered)
//   busy          high while a frame is on the line (registered)
//   frame_count   frames fully sent, wraps at 16 bits
//
// CLKS_PER_BIT must be at least 2.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle; waits for a button change or a pending force
// START | driving the start bit of the current byte
// DATA  | driving data bits, LSB first (bit_idx selects the bit)
// STOP  | driving the stop bit; then next byte or back to IDLE

module pad_uart_reporter #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] pad_btn,
    input  logic        enable,
    input  logic        force_report,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    logic [2:0]    bit_idx_q, bit_idx_nxt;
    logic [2:0]    byte_idx_q, byte_idx_nxt;
    logic [7:0]    byte_q, byte_nxt;
    logic [11:0]   snapshot_q, snapshot_nxt;
    logic [11:0]   last_q, last_nxt;
    logic          force_q, force_nxt;
    logic          tx_q, tx_nxt;
    logic          busy_q, busy_nxt;
    logic [15:0]   frame_count_q, frame_count_nxt;
    logic          bit_done;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [11:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h50;
            3'd1:    b = hex_ascii(snap[11:8]);
            3'd2:    b = hex_ascii(snap[7:4]);
            3'd3:    b = hex_ascii(snap[3:0]);
            3'd4:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Bit timer is a down-counter; a bit ends on its terminal count of zero.
    assign bit_done = (timer_q == '0);

    always_comb begin
        state_nxt       = state_q;
        timer_nxt       = bit_done ? BIT_LAST : timer_q - TW'(1);
        bit_idx_nxt     = bit_idx_q;
        byte_idx_nxt    = byte_idx_q;
        byte_nxt        = byte_q;
        snapshot_nxt    = snapshot_q;
        last_nxt        = last_q;
        force_nxt       = force_q | force_report;
        tx_nxt          = tx_q;
        busy_nxt        = busy_q;
        frame_count_nxt = frame_count_q;

        // uart_tx and busy are registered, so each transition below also
        // sets the line level of the state being entered.
        case (state_q)
            IDLE: begin
                timer_nxt = BIT_LAST;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                if (enable && ((pad_btn != last_q) || force_q)) begin
                    state_nxt    = START;
                    snapshot_nxt = pad_btn;
                    last_nxt     = pad_btn;
                    // A force arriving on the start cycle belongs to the next frame.
                    force_nxt    = force_report;
                    byte_idx_nxt = 3'd0;
                    byte_nxt     = frame_byte(3'd0, pad_btn);
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    tx_nxt      = byte_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx_q + 3'd1;
                        tx_nxt      = byte_q[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx_q < 3'd5) begin
                        state_nxt    = START;
                        byte_idx_nxt = byte_idx_q + 3'd1;
                        byte_nxt     = frame_byte(byte_idx_q + 3'd1, snapshot_q);
                        tx_nxt       = 1'b0;
                    end else begin
                        state_nxt       = IDLE;
                        busy_nxt        = 1'b0;
                        tx_nxt          = 1'b1;
                        frame_count_nxt = frame_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= BIT_LAST;
            bit_idx_q     <= 3'd0;
            byte_idx_q    <= 3'd0;
            byte_q        <= 8'h00;
            snapshot_q    <= 12'h000;
            last_q        <= 12'h000;
            force_q       <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_nxt;
            timer_q       <= timer_nxt;
            bit_idx_q     <= bit_idx_nxt;
            byte_idx_q    <= byte_idx_nxt;
            byte_q        <= byte_nxt;
            snapshot_q    <= snapshot_nxt;
            last_q        <= last_nxt;
            force_q       <= force_nxt;
            tx_q          <= tx_nxt;
            busy_q        <= busy_nxt;
            frame_count_q <= frame_count_nxt;
        end
    end

    assign uart_tx     = tx_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pad_uart_reporter.sv
// Directed bench for pad_uart_reporter at 4 clocks per UART bit.
// A frame is 240 cycles; bit k of byte b starts at cycle 40*b + 4*k after the
// first start-bit cycle and is sampled two cycles in.
module tb_pad_uart_reporter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pad_btn;
    logic        enable;
    logic        force_report;
    logic        uart_tx;
    logic        busy;
    logic [15:0] frame_count;

    int passed = 0;
    int total  = 0;
    int n;

    pad_uart_reporter #(
        .CLK_HZ(1000000),
        .BAUD  (250000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pad_btn     (pad_btn),
        .enable      (enable),
        .force_report(force_report),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts cycles in which the line is not idle.
    task automatic quiet(input int cycles, output int bad);
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
    endtask

    // Called on the first start-bit cycle; returns on the cycle after the frame.
    task automatic rx_frame(input string tag, input logic [47:0] exp,
                            input bit mid_en, input logic [11:0] mid_a,
                            input logic [11:0] mid_b, input bit force_en);
        logic [7:0]  got [6];
        logic [47:0] got_all;
        int          frame_errs;
        int          busy_errs;
        int          k;
        int          b;
        frame_errs = 0;
        busy_errs  = 0;
        for (int i = 0; i < 6; i++) got[i] = 8'h00;
        for (int c = 0; c < 240; c++) begin
            if (mid_en && c == 85)  pad_btn = mid_a;
            if (mid_en && c == 125) pad_btn = mid_b;
            if (force_en) force_report = (c == 90 || c == 170);
            if (c % 4 == 2) begin
                k = (c % 40) / 4;
                b = c / 40;
                if (k == 0) begin
                    if (uart_tx !== 1'b0) frame_errs++;
                end else if (k == 9) begin
                    if (uart_tx !== 1'b1) frame_errs++;
                end else begin
                    got[b][k-1] = uart_tx;
                end
            end
            if (busy !== 1'b1) busy_errs++;
            tick();
        end
        got_all = {got[0], got[1], got[2], got[3], got[4], got[5]};
        chk({tag, "_bytes"}, got_all, exp);
        chk({tag, "_framing"}, 48'(frame_errs), 48'd0);
        chk({tag, "_busy240"}, 48'(busy_errs), 48'd0);
        chk({tag, "_end_idle"}, {46'd0, uart_tx, busy}, {46'd0, 2'b10});
    endtask

    initial begin
        reset_n      = 1'b0;
        pad_btn      = 12'h000;
        enable       = 1'b1;
        force_report = 1'b0;
        repeat (3) tick();
        chk("rst_tx", 48'(uart_tx), 48'd1);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_count", 48'(frame_count), 48'd0);

        reset_n = 1'b1;
        quiet(500, n);
        chk("idle_no_frame", 48'(n), 48'd0);
        chk("idle_count", 48'(frame_count), 48'd0);

        // Change to 0xA5C; a glitch to 0x001 and back mid-frame must not report.
        pad_btn = 12'hA5C;
        tick();
        chk("a5c_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        rx_frame("a5c", 48'h504135430D0A, 1'b1, 12'h001, 12'hA5C, 1'b0);
        chk("a5c_count", 48'(frame_count), 48'd1);
        quiet(300, n);
        chk("revert_no_frame", 48'(n), 48'd0);
        chk("revert_count", 48'(frame_count), 48'd1);

        // Forced frame; during it pad goes to 0x0F0 and two forces arrive.
        force_report = 1'b1;
        tick();
        force_report = 1'b0;
        tick();
        chk("force_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        rx_frame("force_a5c", 48'h504135430D0A, 1'b1, 12'h0F0, 12'h0F0, 1'b1);
        chk("force_count", 48'(frame_count), 48'd2);
        tick();
        chk("back_to_back", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        rx_frame("p0f0", 48'h503046300D0A, 1'b0, 12'h000, 12'h000, 1'b0);
        chk("p0f0_count", 48'(frame_count), 48'd3);
        quiet(500, n);
        chk("force_consumed", 48'(n), 48'd0);
        chk("force_consumed_count", 48'(frame_count), 48'd3);

        // Disabled: change is held until enable rises.
        enable  = 1'b0;
        pad_btn = 12'h123;
        quiet(1000, n);
        chk("disabled_quiet", 48'(n), 48'd0);
        enable = 1'b1;
        tick();
        chk("enable_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        rx_frame("p123", 48'h503132330D0A, 1'b0, 12'h000, 12'h000, 1'b0);
        chk("p123_count", 48'(frame_count), 48'd4);

        // Reset during byte 3 aborts the frame.
        pad_btn = 12'h456;
        tick();
        chk("p456_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        repeat (130) tick();
        reset_n = 1'b0;
        tick();
        chk("abort_tx_busy", {46'd0, uart_tx, busy}, {46'd0, 2'b10});
        chk("abort_count", 48'(frame_count), 48'd0);
        reset_n = 1'b1;
        pad_btn = 12'h123;
        tick();
        chk("post_reset_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
        rx_frame("post_reset", 48'h503132330D0A, 1'b0, 12'h000, 12'h000, 1'b0);
        chk("post_reset_count", 48'(frame_count), 48'd1);

        // Preload the counter near the top and send two forced frames.
        dut.frame_count_q = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            force_report = 1'b1;
            tick();
            force_report = 1'b0;
            tick();
            chk("wrap_latency", {46'd0, uart_tx, busy}, {46'd0, 2'b01});
            rx_frame("wrap", 48'h503132330D0A, 1'b0, 12'h000, 12'h000, 1'b0);
            chk("wrap_count", 48'(frame_count), (f == 0) ? 48'hFFFF : 48'h0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
